// File: rtl/types_amba_pkg.sv
// AMBA AXI4 system-bus types shared by bus masters and slaves.
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS  = 48;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = 8;
    localparam int CFG_SYSBUS_ID_BITS    = 5;
    localparam int CFG_SYSBUS_USER_BITS  = 1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0] addr;
        logic [7:0]                      len;
        logic [2:0]                      size;
        logic [1:0]                      burst;
        logic                            lock;
        logic [3:0]                      cache;
        logic [2:0]                      prot;
        logic [3:0]                      qos;
        logic [3:0]                      region;
    } axi4_metadata_type;

    localparam axi4_metadata_type META_NONE = '{
        addr: '0, len: '0, size: '0, burst: AXI_BURST_INCR, lock: 1'b0,
        cache: '0, prot: '0, qos: '0, region: '0
    };

    typedef struct packed {
        logic                             aw_valid;
        axi4_metadata_type                aw_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
        logic                             w_valid;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
        logic                             w_last;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0]  w_user;
        logic                             b_ready;
        logic                             ar_valid;
        axi4_metadata_type                ar_bits;
        logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
        logic                             r_ready;
    } axi4_master_out_type;

    localparam axi4_master_out_type axi4_master_out_none = '{
        aw_valid: 1'b0, aw_bits: META_NONE, aw_id: '0, aw_user: '0,
        w_valid: 1'b0, w_data: '0, w_last: 1'b0, w_strb: '0, w_user: '0,
        b_ready: 1'b0, ar_valid: 1'b0, ar_bits: META_NONE, ar_id: '0,
        ar_user: '0, r_ready: 1'b0
    };

    typedef struct packed {
        logic                             aw_ready;
        logic                             w_ready;
        logic                             b_valid;
        logic [1:0]                       b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]    b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  b_user;
        logic                             ar_ready;
        logic                             r_valid;
        logic [1:0]                       r_resp;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  r_data;
        logic                             r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]    r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0]  r_user;
    } axi4_master_in_type;

    localparam axi4_master_in_type axi4_master_in_none = '{
        aw_ready: 1'b0, w_ready: 1'b0, b_valid: 1'b0, b_resp: '0, b_id: '0,
        b_user: '0, ar_ready: 1'b0, r_valid: 1'b0, r_resp: '0, r_data: '0,
        r_last: 1'b0, r_id: '0, r_user: '0
    };

endpackage

// File: rtl/axi4_req_master.sv
// Single-outstanding AXI4 master: turns one read/write request into a
// single-beat AXI4 transaction and returns data/completion with an error flag.
module axi4_req_master
    import types_amba_pkg::*;
#(
    parameter int                            async_reset = 0,
    parameter logic [CFG_SYSBUS_ID_BITS-1:0] xid         = '0
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             i_req_valid,
    output logic                             o_req_ready,
    input  logic                             i_req_write,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
    input  logic [2:0]                       i_req_size,
    input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
    input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
    output logic                             o_resp_valid,
    input  logic                             i_resp_ready,
    output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
    output logic                             o_resp_err,
    output logic                             o_busy,
    output axi4_master_out_type              o_xmsto,
    input  axi4_master_in_type               i_xmsti
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, RESP} state_t;

    state_t                           state_reg, state_next;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  addr_reg, addr_next;
    logic [2:0]                       size_reg, size_next;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata_reg, wdata_next;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb_reg, wstrb_next;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  rdata_reg, rdata_next;
    logic                             err_reg, err_next;
    logic                             aw_done_reg, aw_done_next;
    logic                             w_done_reg, w_done_next;
    logic                             aw_valid_reg, aw_valid_next;
    logic                             w_valid_reg, w_valid_next;
    logic                             ar_valid_reg, ar_valid_next;
    logic                             r_ready_reg, r_ready_next;
    logic                             b_ready_reg, b_ready_next;
    logic                             req_ready_reg, req_ready_next;
    logic                             resp_valid_reg, resp_valid_next;

    logic aw_hs;
    logic w_hs;

    // Response-code low bits and user sidebands carry nothing this bridge needs.
    logic unused_inputs;
    assign unused_inputs = ^{i_xmsti.b_resp[0], i_xmsti.r_resp[0],
                             i_xmsti.b_user, i_xmsti.r_user, (async_reset != 0)};

    assign aw_hs = aw_valid_reg & i_xmsti.aw_ready;
    assign w_hs  = w_valid_reg & i_xmsti.w_ready;

    // State and registered handshake outputs; everything clears on reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            size_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            aw_valid_reg   <= 1'b0;
            w_valid_reg    <= 1'b0;
            ar_valid_reg   <= 1'b0;
            r_ready_reg    <= 1'b0;
            b_ready_reg    <= 1'b0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            size_reg       <= size_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
            aw_valid_reg   <= aw_valid_next;
            w_valid_reg    <= w_valid_next;
            ar_valid_reg   <= ar_valid_next;
            r_ready_reg    <= r_ready_next;
            b_ready_reg    <= b_ready_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
        end
    end

    // Next-state logic; each valid/ready is computed one cycle ahead so it
    // leaves the block straight from a flop.
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        size_next       = size_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        aw_done_next    = aw_done_reg;
        w_done_next     = w_done_reg;
        aw_valid_next   = aw_valid_reg;
        w_valid_next    = w_valid_reg;
        ar_valid_next   = ar_valid_reg;
        r_ready_next    = r_ready_reg;
        b_ready_next    = b_ready_reg;
        req_ready_next  = req_ready_reg;
        resp_valid_next = resp_valid_reg;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (i_req_valid && req_ready_reg) begin
                    req_ready_next = 1'b0;
                    addr_next      = i_req_addr;
                    size_next      = i_req_size;
                    wdata_next     = i_req_wdata;
                    wstrb_next     = i_req_wstrb;
                    aw_done_next   = 1'b0;
                    w_done_next    = 1'b0;
                    if (i_req_write) begin
                        state_next    = WREQ;
                        aw_valid_next = 1'b1;
                        w_valid_next  = 1'b1;
                    end else begin
                        state_next    = RADDR;
                        ar_valid_next = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (ar_valid_reg && i_xmsti.ar_ready) begin
                    ar_valid_next = 1'b0;
                    r_ready_next  = 1'b1;
                    state_next    = RDATA;
                end
            end
            RDATA: begin
                if (r_ready_reg && i_xmsti.r_valid) begin
                    rdata_next      = i_xmsti.r_data;
                    err_next        = i_xmsti.r_resp[1] | (i_xmsti.r_id != xid)
                                      | !i_xmsti.r_last;
                    r_ready_next    = 1'b0;
                    resp_valid_next = 1'b1;
                    state_next      = RESP;
                end
            end
            WREQ: begin
                // AW and W retire independently; leave once both have.
                if (aw_hs) begin
                    aw_valid_next = 1'b0;
                    aw_done_next  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                end
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    b_ready_next = 1'b1;
                    state_next   = WRESP;
                end
            end
            WRESP: begin
                if (b_ready_reg && i_xmsti.b_valid) begin
                    rdata_next      = '0;
                    err_next        = i_xmsti.b_resp[1] | (i_xmsti.b_id != xid);
                    b_ready_next    = 1'b0;
                    resp_valid_next = 1'b1;
                    state_next      = RESP;
                end
            end
            RESP: begin
                if (resp_valid_reg && i_resp_ready) begin
                    resp_valid_next = 1'b0;
                    req_ready_next  = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Assemble the AXI master bundle; unused fields keep their idle values.
    always_comb begin
        o_xmsto               = axi4_master_out_none;
        o_xmsto.aw_valid      = aw_valid_reg;
        o_xmsto.aw_bits.addr  = addr_reg;
        o_xmsto.aw_bits.size  = size_reg;
        o_xmsto.aw_id         = xid;
        o_xmsto.w_valid       = w_valid_reg;
        o_xmsto.w_data        = wdata_reg;
        o_xmsto.w_strb        = wstrb_reg;
        // Single-beat bursts: every presented beat is the last one.
        o_xmsto.w_last        = w_valid_reg;
        o_xmsto.b_ready       = b_ready_reg;
        o_xmsto.ar_valid      = ar_valid_reg;
        o_xmsto.ar_bits.addr  = addr_reg;
        o_xmsto.ar_bits.size  = size_reg;
        o_xmsto.ar_id         = xid;
        o_xmsto.r_ready       = r_ready_reg;
    end

    assign o_req_ready  = req_ready_reg;
    assign o_resp_valid = resp_valid_reg;
    assign o_resp_rdata = rdata_reg;
    assign o_resp_err   = err_reg;
    assign o_busy       = (state_reg != IDLE);

endmodule
